// File: rtl/jtdd_scr_romrq_if.sv
// Scroll-layer ROM fetch bus: layer-side address/data and SDRAM-arbiter side
// request/ack/data. The slave modport belongs to the ROM responder.
interface jtdd_scr_romrq_if #(
  parameter int AW = 17
);
  logic [AW-1:0] addr;
  logic          addr_ok;
  logic [21:0]   sdram_addr;
  logic          sdram_req;
  logic          sdram_ack;
  logic          data_dst;
  logic          data_rdy;
  logic [31:0]   din;
  logic [15:0]   dout;
  logic          data_ok;

  modport master (
    output addr, addr_ok, sdram_ack, data_dst, data_rdy, din,
    input  sdram_addr, sdram_req, dout, data_ok
  );

  modport slave (
    input  addr, addr_ok, sdram_ack, data_dst, data_rdy, din,
    output sdram_addr, sdram_req, dout, data_ok
  );
endinterface

// File: rtl/jtdd_scr_romrq.sv
// SDRAM-side responder for the scroll layer ROM port. Serves halfwords from a
// two-entry 32-bit word cache; misses issue one SDRAM read and fill the cache.
module jtdd_scr_romrq #(
  parameter int AW      = 17,
  parameter bit SWAP_A0 = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [21:0]           offset,
  jtdd_scr_romrq_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_nx;
  logic [AW-2:0] waddr;
  logic [AW-2:0] req_waddr;
  logic [AW-2:0] tag0, tag1;
  logic [31:0]   data0, data1;
  logic [1:0]    valid;
  logic [1:0]    hit_vec;
  logic          hit;
  logic          hit_sel;
  logic          victim;
  logic          fill_sel;
  logic          fill;
  logic          load_req;
  logic [21:0]   sdram_addr_r;
  logic [15:0]   dout_r;
  logic [AW-1:0] served_addr;
  logic          served_valid;
  logic [31:0]   hit_word;

  function automatic logic [15:0] pick(input logic [31:0] w, input logic a0);
    return (a0 ^ SWAP_A0) ? w[31:16] : w[15:0];
  endfunction

  assign waddr = bus.addr[AW-1:1];

  // Cache lookup against the current layer address
  always_comb begin
    hit_vec    = '0;
    hit_vec[0] = bus.addr_ok && valid[0] && (tag0 == waddr);
    hit_vec[1] = bus.addr_ok && valid[1] && (tag1 == waddr);
    hit        = |hit_vec;
    hit_sel    = hit_vec[1];
    hit_word   = hit_sel ? data1 : data0;
    // A fill never lands on the entry being hit-served this cycle, unless both
    // entries hit (duplicate tags) in which case either is equivalent.
    fill_sel   = (hit_vec[victim] && !hit_vec[~victim]) ? ~victim : victim;
  end

  // Next-state and request/fill strobes
  always_comb begin
    state_nx = state;
    load_req = 1'b0;
    fill     = 1'b0;
    case (state)
      IDLE: if (bus.addr_ok && !hit) begin
        state_nx = REQ;
        load_req = 1'b1;
      end
      REQ:  if (bus.sdram_ack) state_nx = WAIT;
      WAIT: if (bus.data_dst && bus.data_rdy) begin
        fill     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Request address and requested word, captured when entering REQ
  always_ff @(posedge clk) begin
    if (rst) begin
      sdram_addr_r <= '0;
      req_waddr    <= '0;
    end else if (load_req) begin
      sdram_addr_r <= offset + 22'({waddr, 1'b0});
      req_waddr    <= waddr;
    end
  end

  // Cache fill with round-robin victim
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= '0;
      victim <= 1'b0;
      tag0   <= '0;
      tag1   <= '0;
      data0  <= '0;
      data1  <= '0;
    end else if (fill) begin
      valid[fill_sel] <= 1'b1;
      victim          <= ~fill_sel;
      if (fill_sel) begin
        tag1  <= req_waddr;
        data1 <= bus.din;
      end else begin
        tag0  <= req_waddr;
        data0 <= bus.din;
      end
    end
  end

  // Halfword output: from a hit, or straight from a fill matching the address
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r       <= '0;
      served_addr  <= '0;
      served_valid <= 1'b0;
    end else if (hit) begin
      dout_r       <= pick(hit_word, bus.addr[0]);
      served_addr  <= bus.addr;
      served_valid <= 1'b1;
    end else if (fill && bus.addr_ok && (req_waddr == waddr)) begin
      dout_r       <= pick(bus.din, bus.addr[0]);
      served_addr  <= bus.addr;
      served_valid <= 1'b1;
    end
  end

  assign bus.sdram_req  = (state == REQ);
  assign bus.sdram_addr = sdram_addr_r;
  assign bus.dout       = dout_r;
  assign bus.data_ok    = served_valid && (served_addr == bus.addr) && bus.addr_ok;

endmodule

// File: tb/tb_jtdd_scr_romrq.sv
// Scoreboard bench for jtdd_scr_romrq: stimulus queues expected request
// addresses and halfwords; a monitor pops them on request/data_ok events.
module tb_jtdd_scr_romrq;

  logic        clk;
  logic        rst;
  logic [21:0] offset;

  jtdd_scr_romrq_if #(.AW(17)) bus ();

  jtdd_scr_romrq #(.AW(17), .SWAP_A0(1'b0)) dut (
    .clk    (clk),
    .rst    (rst),
    .offset (offset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [21:0] exp_req[$];
  logic [15:0] exp_dat[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: request rising edges and new data_ok presentations
  initial begin
    logic        prev_ok;
    logic        prev_req;
    logic [16:0] prev_addr;
    prev_ok   = 1'b0;
    prev_req  = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.sdram_req && !prev_req) begin
          if (exp_req.size() == 0) flag("unexpected_req");
          else check("req_addr", 32'(bus.sdram_addr), 32'(exp_req.pop_front()));
        end
        if (bus.data_ok && !(prev_ok && prev_addr == bus.addr)) begin
          if (exp_dat.size() == 0) flag("unexpected_data_ok");
          else check("dout", 32'(bus.dout), 32'(exp_dat.pop_front()));
        end
      end
      prev_ok   = rst ? 1'b0 : bus.data_ok;
      prev_req  = rst ? 1'b0 : bus.sdram_req;
      prev_addr = bus.addr;
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_req();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.sdram_req) got = 1'b1;
    end
    if (!got) begin
      flag("req_timeout");
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1 bus.sdram_ack = 1'b1;
    @(posedge clk);
    #1 bus.sdram_ack = 1'b0;
  endtask

  task automatic give_data(input logic [31:0] w, input int unsigned lat);
    idle(lat);
    bus.data_dst = 1'b1;
    bus.data_rdy = 1'b1;
    bus.din      = w;
    @(posedge clk);
    #1;
    bus.data_dst = 1'b0;
    bus.data_rdy = 1'b0;
  endtask

  task automatic serve(input logic [31:0] w, input int unsigned lat);
    ack_req();
    give_data(w, lat);
  endtask

  initial begin
    rst          = 1'b1;
    offset       = '0;
    bus.addr     = '0;
    bus.addr_ok  = 1'b0;
    bus.sdram_ack = 1'b0;
    bus.data_dst = 1'b0;
    bus.data_rdy = 1'b0;
    bus.din      = '0;
    idle(2);
    check("rst_req",     32'(bus.sdram_req),  32'd0);
    check("rst_addr",    32'(bus.sdram_addr), 32'd0);
    check("rst_dout",    32'(bus.dout),       32'd0);
    check("rst_data_ok", 32'(bus.data_ok),    32'd0);

    // 1: first miss and fill
    offset      = 22'h10000;
    bus.addr    = 17'h00004;
    bus.addr_ok = 1'b1;
    exp_req.push_back(22'h10004);
    exp_dat.push_back(16'h1234);
    idle(1);
    rst = 1'b0;
    serve(32'hBEEF_1234, 2);
    idle(3);

    // 2: odd halfword of the same word hits; data_ok drops immediately
    exp_dat.push_back(16'hBEEF);
    bus.addr = 17'h00005;
    #1 check("t2_ok_drop", 32'(bus.data_ok), 32'd0);
    idle(3);
    check("t2_no_req", 32'(bus.sdram_req), 32'd0);
    check("t2_ok",     32'(bus.data_ok),   32'd1);

    // 3: fill words 4 and 6; word 2 is evicted, word 4 still hits
    exp_req.push_back(22'h10008);
    exp_dat.push_back(16'h0008);
    bus.addr = 17'h00008;
    serve(32'h4444_0008, 1);
    idle(2);
    exp_req.push_back(22'h1000C);
    exp_dat.push_back(16'h000C);
    bus.addr = 17'h0000C;
    serve(32'h6666_000C, 0);
    idle(2);
    exp_dat.push_back(16'h0008);
    bus.addr = 17'h00008;
    idle(3);
    exp_req.push_back(22'h10004);
    exp_dat.push_back(16'h1234);
    bus.addr = 17'h00004;
    serve(32'hBEEF_1234, 3);
    idle(2);

    // 4: address moves during WAIT; old word fills, new word requested
    exp_req.push_back(22'h10010);
    bus.addr = 17'h00010;
    ack_req();
    idle(1);
    bus.addr = 17'h00020;
    exp_req.push_back(22'h10020);
    exp_dat.push_back(16'hAAAA);
    give_data(32'h8888_0010, 1);
    check("t4_no_early_ok", 32'(bus.data_ok), 32'd0);
    serve(32'h2020_AAAA, 1);
    idle(2);
    exp_dat.push_back(16'h0010);
    bus.addr = 17'h00010;
    idle(3);

    // 5: request address wraps modulo 2^22
    rst = 1'b1;
    idle(1);
    offset   = 22'h3FFFF0;
    bus.addr = 17'h00020;
    exp_req.push_back(22'h000010);
    exp_dat.push_back(16'h6666);
    rst = 1'b0;
    serve(32'h5555_6666, 2);
    idle(2);

    // 6: reset during WAIT aborts; late and stray data are ignored
    offset = 22'h10000;
    exp_req.push_back(22'h10030);
    bus.addr = 17'h00030;
    ack_req();
    rst = 1'b1;
    idle(1);
    bus.data_dst = 1'b1;
    bus.data_rdy = 1'b1;
    bus.din      = 32'h3030_1111;
    idle(1);
    bus.data_dst = 1'b0;
    bus.data_rdy = 1'b0;
    bus.addr_ok  = 1'b0;
    rst          = 1'b0;
    idle(1);
    check("t6_ok_after_rst",  32'(bus.data_ok),   32'd0);
    check("t6_req_after_rst", 32'(bus.sdram_req), 32'd0);
    bus.data_dst = 1'b1;
    bus.data_rdy = 1'b1;
    idle(1);
    bus.data_dst = 1'b0;
    bus.data_rdy = 1'b0;
    check("t6_stray_no_req", 32'(bus.sdram_req), 32'd0);
    exp_req.push_back(22'h10030);
    exp_dat.push_back(16'h1111);
    bus.addr_ok = 1'b1;
    serve(32'h3030_1111, 1);
    idle(3);

    check("req_queue_empty", 32'(exp_req.size()), 32'd0);
    check("dat_queue_empty", 32'(exp_dat.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
